pulse_stretch_driver: RTL and testbench

//   Output-side counterpart of the button input path: converts one-cycle clean event

---
 rtl/pulse_drv_pkg.sv | 14 +
 rtl/pulse_stretch_driver_if.sv | 21 ++
 rtl/pulse_stretch_driver_cycle_timer.sv | 24 ++
 rtl/pulse_stretch_driver.sv | 104 ++++++++++
 tb/tb_pulse_stretch_driver.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pulse_drv_pkg.sv
// Shared state encodings for the pulse stretch driver.
package pulse_drv_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ON   = ST_ON,
        S_GAP  = ST_GAP
    } drv_state_t;

endpackage

// File: rtl/pulse_stretch_driver_if.sv
// Event request side and stretched-output side of the pulse stretch driver.
interface pulse_stretch_driver_if #(
    parameter int PEND_W = 3
);
    logic              pulse_in;
    logic              clear;
    logic              pulse_out;
    logic              busy;
    logic [PEND_W-1:0] pending_cnt;
    logic              overflow;

    modport master (
        output pulse_in, clear,
        input  pulse_out, busy, pending_cnt, overflow
    );

    modport slave (
        input  pulse_in, clear,
        output pulse_out, busy, pending_cnt, overflow
    );
endinterface

// File: rtl/pulse_stretch_driver_cycle_timer.sv
// Up-counting phase timer; clr returns it to zero, it holds at the terminal value.
module cycle_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);
    logic [CNT_W-1:0] count;

    assign tc = (count == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (!tc) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/pulse_stretch_driver.sv
// Turns one-cycle events into ON_CYCLES-wide output pulses separated by at least
// OFF_CYCLES low, queueing events that arrive while a pulse is in progress.
//   state  | meaning
//   S_IDLE | output low, nothing pending
//   S_ON   | output high for ON_CYCLES
//   S_GAP  | output low for OFF_CYCLES, then replay or go idle
module pulse_stretch_driver
    import pulse_drv_pkg::*;
#(
    parameter int ON_CYCLES   = 100,
    parameter int OFF_CYCLES  = 100,
    parameter int MAX_PENDING = 7,
    parameter int CNT_W       = 20,
    parameter int PEND_W      = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    pulse_stretch_driver_if.slave  bus
);
    localparam logic [CNT_W-1:0]  ON_TERM  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_TERM = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    drv_state_t       state;
    logic             pulse_in_q;
    logic             event_det;
    logic             tc;
    logic             timer_clr;
    logic             replay;
    logic [CNT_W-1:0] term;

    assign event_det = bus.pulse_in & ~pulse_in_q;
    assign term      = (state == S_ON) ? ON_TERM : OFF_TERM;
    assign timer_clr = bus.clear || tc || (state == S_IDLE);
    // An event landing on the last gap cycle starts the next pulse directly,
    // so it never sits in the queue (and never gets stranded when going idle).
    assign replay    = (state == S_GAP) && tc && ((bus.pending_cnt != '0) || event_det);

    cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (reset),
        .clr   (timer_clr),
        .term  (term),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            pulse_in_q      <= 1'b0;
            bus.pulse_out   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.pending_cnt <= '0;
            bus.overflow    <= 1'b0;
        end else begin
            pulse_in_q   <= bus.pulse_in;
            bus.overflow <= 1'b0;
            if (bus.clear) begin
                state           <= S_IDLE;
                bus.pulse_out   <= 1'b0;
                bus.busy        <= 1'b0;
                bus.pending_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: if (event_det) begin
                        state         <= S_ON;
                        bus.pulse_out <= 1'b1;
                        bus.busy      <= 1'b1;
                    end
                    S_ON: if (tc) begin
                        state         <= S_GAP;
                        bus.pulse_out <= 1'b0;
                    end
                    S_GAP: if (tc) begin
                        if (replay) begin
                            state         <= S_ON;
                            bus.pulse_out <= 1'b1;
                        end else begin
                            state    <= S_IDLE;
                            bus.busy <= 1'b0;
                        end
                    end
                    default: begin
                        state         <= S_IDLE;
                        bus.pulse_out <= 1'b0;
                        bus.busy      <= 1'b0;
                    end
                endcase

                if (state != S_IDLE) begin
                    if (replay && !event_det) begin
                        bus.pending_cnt <= bus.pending_cnt - PEND_W'(1);
                    end else if (event_det && !replay) begin
                        if (bus.pending_cnt == PEND_MAX) begin
                            bus.overflow <= 1'b1;
                        end else begin
                            bus.pending_cnt <= bus.pending_cnt + PEND_W'(1);
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pulse_stretch_driver.sv
// Scoreboard bench: each accepted event pushes the pending count expected in the
// first high cycle of its output pulse; a monitor pops and checks pulse shape.
module tb_pulse_stretch_driver;
    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int MAXP = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pulse_stretch_driver_if #(.PEND_W(3)) bus ();

    pulse_stretch_driver #(
        .ON_CYCLES   (ON),
        .OFF_CYCLES  (OFF),
        .MAX_PENDING (MAXP),
        .CNT_W       (20),
        .PEND_W      (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_miscmp = 0;
    int exp_q[$];
    int n_pulses = 0;
    int n_ov = 0;
    int cut_req = 0;
    int cut_ack = 0;
    int pend_log[32];
    int ov_log[32];

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((bus.busy || bus.pulse_out) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) check_val("idle_timeout", 0, 1);
        tick();
    endtask

    // Bit i of pat drives pulse_in during cycle T+i; logs are taken in cycle T+i+1.
    task automatic drive_pattern(input logic [31:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            bus.pulse_in = pat[i];
            tick();
            pend_log[i] = int'(bus.pending_cnt);
            ov_log[i]   = int'(bus.overflow);
        end
        bus.pulse_in = 1'b0;
    endtask

    // Output monitor
    initial begin
        logic prev_po = 1'b0;
        int   high_len = 0;
        int   low_len = 0;
        bit   have_fall = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.pulse_out && !prev_po) begin
                n_pulses++;
                if (exp_q.size() == 0) check_val("unexpected_pulse", 1, 0);
                else check_val("pend_at_start", int'(bus.pending_cnt), exp_q.pop_front());
                if (have_fall) check_val("gap_min", int'(low_len >= OFF), 1);
                high_len = 1;
            end else if (bus.pulse_out) begin
                high_len++;
            end else if (prev_po) begin
                if (cut_ack != cut_req) cut_ack++;
                else check_val("high_len", high_len, ON);
                low_len = 1;
                have_fall = 1'b1;
            end else begin
                low_len++;
            end
            if (bus.overflow) n_ov++;
            prev_po = bus.pulse_out;
        end
    end

    initial begin
        int p0;
        int o0;
        reset = 1'b0;
        bus.pulse_in = 1'b0;
        bus.clear = 1'b0;

        // reset held with pulse_in toggling
        for (int i = 0; i < 6; i++) begin
            bus.pulse_in = ~bus.pulse_in;
            tick();
            check_val("rst_pulse_out", int'(bus.pulse_out), 0);
        end
        check_val("rst_busy", int'(bus.busy), 0);
        check_val("rst_pending", int'(bus.pending_cnt), 0);
        check_val("rst_overflow", int'(bus.overflow), 0);
        bus.pulse_in = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        check_val("post_rst_busy", int'(bus.busy), 0);
        check_val("post_rst_out", int'(bus.pulse_out), 0);

        // single event: high T+1..T+4, busy drops at T+7
        p0 = n_pulses;
        exp_q.push_back(0);
        bus.pulse_in = 1'b1;
        tick();
        bus.pulse_in = 1'b0;
        check_val("single_t1_out", int'(bus.pulse_out), 1);
        check_val("single_t1_busy", int'(bus.busy), 1);
        tick(); tick(); tick();
        check_val("single_t4_out", int'(bus.pulse_out), 1);
        tick();
        check_val("single_t5_out", int'(bus.pulse_out), 0);
        check_val("single_t5_busy", int'(bus.busy), 1);
        tick();
        check_val("single_t6_busy", int'(bus.busy), 1);
        tick();
        check_val("single_t7_busy", int'(bus.busy), 0);
        tick();
        check_val("single_count", n_pulses - p0, 1);

        // held input counts once
        p0 = n_pulses;
        exp_q.push_back(0);
        drive_pattern(32'h000F_FFFF, 20);
        check_val("held_pending", pend_log[3], 0);
        wait_idle(100);
        check_val("held_count", n_pulses - p0, 1);

        // queue: events at T, T+2, T+4, T+6 (replay cycle), T+8
        p0 = n_pulses;
        o0 = n_ov;
        exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(2);
        exp_q.push_back(1); exp_q.push_back(0);
        drive_pattern(32'h0000_0155, 12);
        check_val("queue_pend_t5", pend_log[4], 2);
        check_val("queue_cancel_t7", pend_log[6], 2);
        check_val("queue_full_t9", pend_log[8], MAXP);
        wait_idle(200);
        check_val("queue_count", n_pulses - p0, 5);
        check_val("queue_no_ovf", n_ov - o0, 0);

        // overflow: extra event at T+10 (queue full, dropped) and T+12 (cancelled by replay)
        p0 = n_pulses;
        o0 = n_ov;
        exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(3);
        exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
        drive_pattern(32'h0000_1555, 16);
        check_val("ovf_pulse_t11", ov_log[10], 1);
        check_val("ovf_low_t12", ov_log[11], 0);
        check_val("ovf_pend_t11", pend_log[10], MAXP);
        check_val("ovf_cancel_t13", pend_log[12], MAXP);
        wait_idle(300);
        check_val("ovf_count", n_pulses - p0, 6);
        check_val("ovf_once", n_ov - o0, 1);

        // clear during replay ON with pending 2 and a same-cycle event
        p0 = n_pulses;
        o0 = n_ov;
        exp_q.push_back(0); exp_q.push_back(2);
        drive_pattern(32'h0000_0055, 8);
        check_val("pre_clear_pend", pend_log[7], 2);
        check_val("pre_clear_out", int'(bus.pulse_out), 1);
        cut_req++;
        bus.pulse_in = 1'b1;
        bus.clear = 1'b1;
        tick();
        bus.pulse_in = 1'b0;
        bus.clear = 1'b0;
        check_val("clear_out", int'(bus.pulse_out), 0);
        check_val("clear_pend", int'(bus.pending_cnt), 0);
        check_val("clear_busy", int'(bus.busy), 0);
        check_val("clear_ovf", int'(bus.overflow), 0);
        for (int i = 0; i < 30; i++) tick();
        check_val("clear_count", n_pulses - p0, 2);
        check_val("clear_no_ovf", n_ov - o0, 0);

        // async reset mid-pulse drops output and queue
        exp_q.push_back(0);
        drive_pattern(32'h0000_0005, 3);
        check_val("mid_rst_pre_pend", int'(bus.pending_cnt), 1);
        cut_req++;
        reset = 1'b0;
        #1;
        check_val("mid_rst_out", int'(bus.pulse_out), 0);
        check_val("mid_rst_pend", int'(bus.pending_cnt), 0);
        check_val("mid_rst_busy", int'(bus.busy), 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check_val("mid_rst_idle", int'(bus.busy), 0);

        check_val("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
